// File: rtl/sar_rnm_pkg.sv
// Shared types and helpers for the real-number-model SAR ADC controller and its DAC.
package sar_rnm_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} sar_state_e;

    localparam real CMP_THRESH = 0.5;

    function automatic real code2volt(input int code, input int nbits, input real vref);
        return real'(code) * vref / real'(1 << nbits);
    endfunction

endpackage

// File: rtl/sar_dac_rnm.sv
// Ideal binary-weighted DAC model: code -> real voltage, purely combinational.
module sar_dac_rnm
    import sar_rnm_pkg::*;
#(
    parameter int  N_BITS = 8,
    parameter real VREF   = 1.0
) (
    input  logic [N_BITS-1:0] code,
    output real               volt
);

    assign volt = code2volt(int'(code), N_BITS, VREF);

endmodule

// File: rtl/sar_adc_ctrl_rnm.sv
// Successive-approximation controller: drives a real DAC into an ideal comparator and
// resolves an N_BITS code MSB first, one bit per clock.
module sar_adc_ctrl_rnm
    import sar_rnm_pkg::*;
#(
    parameter int  N_BITS = 8,
    parameter real VREF   = 1.0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  real               cmp_i,
    output real               dac_o,
    output logic              sample_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_BITS-1:0] data_o,
    output sar_state_e        state_o
);

    // start_i is a level request sampled only in IDLE or DONE (ignored, not queued, while
    // busy); done_o is a one-cycle valid for data_o with no back-pressure from the consumer.

    localparam int            KW    = $clog2(N_BITS);
    localparam logic [KW-1:0] K_MSB = KW'(N_BITS - 1);

    sar_state_e        state_q, state_d;
    logic [N_BITS-1:0] trial_q, trial_d;
    logic [N_BITS-1:0] data_q, data_d;
    logic [KW-1:0]     k_q, k_d;
    logic [N_BITS-1:0] dac_code;
    logic              cmp_bit;

    // NaN fails every ordered comparison, so an invalid comparator output clears the bit.
    assign cmp_bit = (cmp_i >= CMP_THRESH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            trial_q <= '0;
            data_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            trial_q <= trial_d;
            data_q  <= data_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SAMPLE;
            SAMPLE:  state_d = CONVERT;
            CONVERT: if (k_q == '0) state_d = DONE;
            DONE:    state_d = start_i ? SAMPLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trial_d = trial_q;
        data_d  = data_q;
        k_d     = k_q;
        case (state_q)
            SAMPLE: begin
                trial_d             = '0;
                trial_d[N_BITS-1]   = 1'b1;
                k_d                 = K_MSB;
            end
            CONVERT: begin
                trial_d[k_q] = cmp_bit;
                if (k_q != '0) begin
                    trial_d[k_q - 1'b1] = 1'b1;
                    k_d                 = k_q - 1'b1;
                end else begin
                    // Result is published on DONE entry and held until the next one.
                    data_d = trial_d;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sample_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        dac_code = '0;
        case (state_q)
            SAMPLE: begin
                sample_o = 1'b1;
                busy_o   = 1'b1;
            end
            CONVERT: begin
                busy_o   = 1'b1;
                dac_code = trial_q;
            end
            DONE: begin
                done_o   = 1'b1;
                dac_code = trial_q;
            end
            default: ;
        endcase
    end

    assign data_o  = data_q;
    assign state_o = state_q;

    sar_dac_rnm #(
        .N_BITS (N_BITS),
        .VREF   (VREF)
    ) u_dac (
        .code (dac_code),
        .volt (dac_o)
    );

endmodule

// File: tb/tb_sar_adc_ctrl_rnm.sv
// Self-checking bench for sar_adc_ctrl_rnm with an ideal comparator closing the loop.
module tb_sar_adc_ctrl_rnm;
    import sar_rnm_pkg::*;

    localparam int  NB  = 8;
    localparam real VR  = 1.0;
    localparam real LSB = VR / 256.0;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    real            cmp;
    real            dac;
    logic           sample;
    logic           busy;
    logic           done;
    logic [NB-1:0]  data;
    sar_state_e     st;

    real            vin;
    real            tr[8];
    logic [NB-1:0]  exp_q[$];
    int             check_cnt = 0;
    int             pass_cnt  = 0;

    always #5 clk = ~clk;

    // Ideal comparator: p_i = vin, n_i = dac
    always_comb cmp = (vin > dac) ? 1.0 : 0.0;

    sar_adc_ctrl_rnm #(
        .N_BITS (NB),
        .VREF   (VR)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .cmp_i    (cmp),
        .dac_o    (dac),
        .sample_o (sample),
        .busy_o   (busy),
        .done_o   (done),
        .data_o   (data),
        .state_o  (st)
    );

    // Largest code whose DAC level lies strictly below the input.
    function automatic logic [NB-1:0] ref_code(input real v);
        int c = 0;
        for (int i = 0; i < 256; i++)
            if (real'(i) * LSB < v) c = i;
        return NB'(c);
    endfunction

    // Binary-search trial level for bit b given the final code.
    function automatic real ref_trial(input logic [NB-1:0] code, input int b);
        int ci = int'(code);
        return real'(((ci >> (b + 1)) << (b + 1)) | (1 << b)) * LSB;
    endfunction

    task automatic run_conv(input real v, output int lat, output int n_samp, output logic [NB-1:0] got);
        int n_tr;
        vin = v;
        exp_q.push_back(ref_code(v));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = -1; n_samp = 0; n_tr = 0; got = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (sample) n_samp++;
            if (busy && !sample && n_tr < 8) begin
                tr[n_tr] = dac;
                n_tr++;
            end
            if (done) begin
                lat = c;
                got = data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; vin = 0.0;
        #1;
        check_cnt++;
        if (data !== '0 || busy !== 1'b0 || done !== 1'b0 || sample !== 1'b0 || st !== IDLE)
            $display("FAIL reset_outputs: data=%0d busy=%b done=%b sample=%b required 0/0/0/0", data, busy, done, sample);
        else pass_cnt++;
        check_cnt++;
        if (dac != 0.0) $display("FAIL reset_dac: got %f required 0.0", dac);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (dac != 0.0 || busy !== 1'b0) $display("FAIL idle_after_reset: dac=%f busy=%b required 0.0/0", dac, busy);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int lat, ns; logic [NB-1:0] got, e;
        run_conv(0.3, lat, ns, got);
        e = exp_q.pop_front();
        check_cnt++;
        if (lat !== NB + 2) $display("FAIL single_latency: got %0d required %0d", lat, NB + 2);
        else pass_cnt++;
        check_cnt++;
        if (ns !== 1) $display("FAIL single_sample_count: got %0d required 1", ns);
        else pass_cnt++;
        check_cnt++;
        if (got !== e || got !== 8'd76) $display("FAIL single_data: got %0d required %0d", got, e);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (tr[k] != ref_trial(e, 7 - k))
                $display("FAIL trace_bit%0d: got %f required %f", 7 - k, tr[k], ref_trial(e, 7 - k));
            else pass_cnt++;
        end
        @(negedge clk);
        check_cnt++;
        if (data !== e || done !== 1'b0 || dac != 0.0)
            $display("FAIL single_hold: data=%0d done=%b dac=%f required %0d/0/0.0", data, done, dac, e);
        else pass_cnt++;
    endtask

    task automatic test_boundaries();
        real vs[6];
        int lat, ns; logic [NB-1:0] got, e;
        vs[0] = 0.5; vs[1] = 0.0; vs[2] = 0.999; vs[3] = -0.2; vs[4] = 1.5; vs[5] = 255.0 * LSB;
        for (int i = 0; i < 6; i++) begin
            run_conv(vs[i], lat, ns, got);
            e = exp_q.pop_front();
            check_cnt++;
            if (got !== e || lat !== NB + 2)
                $display("FAIL boundary_%0d: vin=%f data=%0d lat=%0d required %0d/%0d", i, vs[i], got, lat, e, NB + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int lat, ns; logic [NB-1:0] got, e; real v;
        for (int i = 0; i < 10; i++) begin
            v = real'($urandom_range(0, 12000)) / 10000.0 - 0.1;
            run_conv(v, lat, ns, got);
            e = exp_q.pop_front();
            check_cnt++;
            if (got !== e || lat !== NB + 2)
                $display("FAIL random_%0d: vin=%f data=%0d lat=%0d required %0d/%0d", i, v, got, lat, e, NB + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0; int n_samp = 0; logic [NB-1:0] e, at_done = '0;
        vin = 0.3;
        e = ref_code(vin);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            if (sample) n_samp++;
            if (done) begin
                n_done++;
                at_done = data;
            end
        end
        check_cnt++;
        if (n_done !== 1 || n_samp !== 1) $display("FAIL ignore_start_count: done=%0d sample=%0d required 1/1", n_done, n_samp);
        else pass_cnt++;
        check_cnt++;
        if (at_done !== e || data !== e) $display("FAIL ignore_start_data: got %0d/%0d required %0d", at_done, data, e);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int last = 0; int n_done = 0; int bad = 0; logic [NB-1:0] e;
        vin = real'($urandom_range(0, 10000)) / 10000.0;
        exp_q.push_back(ref_code(vin));
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy === done) bad++;
            if (done) begin
                e = exp_q.pop_front();
                n_done++;
                check_cnt++;
                if (c - last !== NB + 2) $display("FAIL b2b_interval_%0d: got %0d required %0d", n_done, c - last, NB + 2);
                else pass_cnt++;
                check_cnt++;
                if (data !== e) $display("FAIL b2b_data_%0d: got %0d required %0d", n_done, data, e);
                else pass_cnt++;
                last = c;
                if (n_done == 4) begin
                    start = 1'b0;
                    break;
                end
                vin = real'($urandom_range(0, 10000)) / 10000.0;
                exp_q.push_back(ref_code(vin));
            end
        end
        check_cnt++;
        if (n_done !== 4 || bad !== 0) $display("FAIL b2b_busy: done=%0d busy_errors=%0d required 4/0", n_done, bad);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || sample !== 1'b0)
            $display("FAIL b2b_stop: busy=%b done=%b sample=%b required 0/0/0", busy, done, sample);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, ns; logic [NB-1:0] got, e;
        run_conv(0.6, lat, ns, got);
        e = exp_q.pop_front();
        check_cnt++;
        if (got !== e) $display("FAIL pre_reset_data: got %0d required %0d", got, e);
        else pass_cnt++;
        vin = 0.3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (data !== '0 || busy !== 1'b0 || done !== 1'b0 || sample !== 1'b0 || dac != 0.0)
            $display("FAIL mid_reset: data=%0d busy=%b done=%b sample=%b dac=%f required 0/0/0/0/0.0",
                     data, busy, done, sample, dac);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        run_conv(0.3, lat, ns, got);
        e = exp_q.pop_front();
        check_cnt++;
        if (got !== e || lat !== NB + 2) $display("FAIL post_reset_conv: data=%0d lat=%0d required %0d/%0d", got, lat, e, NB + 2);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_boundaries();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
